// File: rtl/lifo_stack.sv
// lifo_stack -- parametrised LIFO stack with occupancy, top-of-stack peek,
// same-cycle push+pop replace and sticky overflow/underflow flags.
//
// Ports:
//   clk, rst      rising-edge clock; synchronous active-high reset
//   push_enable   push request this cycle, word on push_data
//   pop_enable    pop request this cycle
//   pop_data      registered popped word, holds until the next successful pop
//   pop_valid     registered, high the cycle after a successful pop
//   top_data      combinational view of the top entry, 0 when empty
//   count         occupancy 0..DEPTH; empty/full decoded from it
//   overflow      sticky: a push was rejected (push only, stack full)
//   underflow     sticky: a pop was rejected (pop only, stack empty)
//   clear_err     clears both sticky flags; a same-cycle rejection still sets
//
// Handshake: there is no back-pressure. A request is taken on the rising edge
// where its enable is high. Whether it succeeds is decided from count before
// that edge. A rejected request only raises its sticky flag. pop_valid marks
// the one cycle in which pop_data carries a freshly popped word.
module lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_enable,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop_enable,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       pop_valid,
  output logic [WIDTH-1:0]           top_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clear_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   SP_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   SP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      sp;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;

  logic do_push;     // push only, room available
  logic do_pop;      // pop only, something to pop
  logic do_replace;  // push+pop on a non-empty stack
  logic do_pass;     // push+pop on an empty stack: word goes straight through
  logic ovf_evt;
  logic unf_evt;

  assign count = sp;
  assign empty = (sp == '0);
  assign full  = (sp == SP_FULL);

  // With sp == DEPTH the low AW bits are 0, so the subtraction wraps to
  // DEPTH-1, which is the correct top index. The index is only used when
  // the stack is not empty.
  assign top_idx  = sp[AW-1:0] - IDX_ONE;
  assign push_idx = sp[AW-1:0];

  assign top_data = empty ? '0 : mem[top_idx];

  always_comb begin
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_replace = 1'b0;
    do_pass    = 1'b0;
    ovf_evt    = 1'b0;
    unf_evt    = 1'b0;
    if (push_enable && pop_enable) begin
      do_replace = !empty;
      do_pass    = empty;
    end else if (push_enable) begin
      do_push = !full;
      ovf_evt = full;
    end else if (pop_enable) begin
      do_pop  = !empty;
      unf_evt = empty;
    end
  end

  // Storage has no reset. Writes are blocked during reset so that rst wins
  // over a same-cycle push.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_push) begin
        mem[push_idx] <= push_data;
      end else if (do_replace) begin
        mem[top_idx] <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= do_pop || do_replace || do_pass;
      if (do_pop || do_replace) begin
        pop_data <= mem[top_idx];
      end else if (do_pass) begin
        pop_data <= push_data;
      end
      if (do_push) begin
        sp <= sp + SP_ONE;
      end else if (do_pop) begin
        sp <= sp - SP_ONE;
      end
      // A new rejection beats clear_err. The flag that was not hit is cleared.
      overflow  <= ovf_evt || (overflow  && !clear_err);
      underflow <= unf_evt || (underflow && !clear_err);
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
module tb_lifo_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             push_enable;
  logic [WIDTH-1:0] push_data;
  logic             pop_enable;
  logic             clear_err;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic [WIDTH-1:0] top_data;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .push_enable (push_enable),
    .push_data   (push_data),
    .pop_enable  (pop_enable),
    .pop_data    (pop_data),
    .pop_valid   (pop_valid),
    .top_data    (top_data),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .underflow   (underflow),
    .clear_err   (clear_err)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model. The queue holds the stack contents, with the top at the end.
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_pop_data;
  logic             m_pop_valid;
  logic             m_ovf;
  logic             m_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic pu, input logic [WIDTH-1:0] d,
                              input logic po, input logic ce);
    int n;
    n = exp_q.size();
    if (r) begin
      exp_q.delete();
      m_pop_data  = '0;
      m_pop_valid = 1'b0;
      m_ovf       = 1'b0;
      m_unf       = 1'b0;
    end else begin
      m_pop_valid = 1'b0;
      if (ce) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (pu && po) begin
        m_pop_valid = 1'b1;
        if (n == 0) begin
          m_pop_data = d;
        end else begin
          m_pop_data = exp_q[n-1];
          exp_q[n-1] = d;
        end
      end else if (pu) begin
        if (n == DEPTH) m_ovf = 1'b1;
        else exp_q.push_back(d);
      end else if (po) begin
        if (n == 0) m_unf = 1'b1;
        else begin
          m_pop_data  = exp_q.pop_back();
          m_pop_valid = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    int n;
    logic [WIDTH-1:0] t;
    n = exp_q.size();
    t = (n == 0) ? '0 : exp_q[n-1];
    check("count", 32'(count), 32'(n));
    check("empty", 32'(empty), 32'(n == 0));
    check("full", 32'(full), 32'(n == DEPTH));
    check("top_data", 32'(top_data), 32'(t));
    check("pop_valid", 32'(pop_valid), 32'(m_pop_valid));
    check("pop_data", 32'(pop_data), 32'(m_pop_data));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // driver: inputs change at negedge, the DUT clocks at posedge, and the
  // outputs are sampled at the following negedge
  task automatic step(input logic r, input logic pu, input logic [WIDTH-1:0] d,
                      input logic po, input logic ce);
    rst         = r;
    push_enable = pu;
    push_data   = d;
    pop_enable  = po;
    clear_err   = ce;
    @(posedge clk);
    model_update(r, pu, d, po, ce);
    @(negedge clk);
    check_all();
  endtask

  task automatic push(input logic [WIDTH-1:0] d); step(1'b0, 1'b1, d, 1'b0, 1'b0); endtask
  task automatic pop();                          step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); endtask

  initial begin
    rst = 1'b1; push_enable = 1'b0; push_data = '0; pop_enable = 1'b0; clear_err = 1'b0;
    exp_q.delete();
    m_pop_data = '0; m_pop_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_top", 32'(top_data), 32'd0);

    // basic push / pop order
    push(8'h11); push(8'h22); push(8'h33);
    check("p3_count", 32'(count), 32'd3);
    check("p3_top", 32'(top_data), 32'h33);
    pop();
    check("pop1", 32'(pop_data), 32'h33);
    pop();
    check("pop2", 32'(pop_data), 32'h22);
    check("pop2_valid", 32'(pop_valid), 32'd1);
    pop();
    check("pop3", 32'(pop_data), 32'h11);
    check("pop3_empty", 32'(empty), 32'd1);

    // overflow
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    push(8'hFF);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_top", 32'(top_data), 32'hA3);
    pop();
    check("ovf_pop", 32'(pop_data), 32'hA3);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // replace on a full stack
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    push(8'hA3);
    step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
    check("rep_pop", 32'(pop_data), 32'hA3);
    check("rep_top", 32'(top_data), 32'h5A);
    check("rep_count", 32'(count), 32'd4);
    check("rep_ovf", 32'(overflow), 32'd0);

    // underflow
    for (int i = 0; i < 4; i++) pop();
    pop();
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_valid", 32'(pop_valid), 32'd0);
    check("unf_hold", 32'(pop_data), 32'hA0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("unf_clr_wins", 32'(underflow), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("unf_cleared", 32'(underflow), 32'd0);

    // pass-through on an empty stack
    step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
    check("pass_data", 32'(pop_data), 32'h77);
    check("pass_valid", 32'(pop_valid), 32'd1);
    check("pass_count", 32'(count), 32'd0);

    // reset beats a push while overflow is set
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    push(8'hEE);
    pop(); pop();
    check("pre_rst_count", 32'(count), 32'd2);
    step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    check("rst2_count", 32'(count), 32'd0);
    check("rst2_top", 32'(top_data), 32'd0);
    check("rst2_ovf", 32'(overflow), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 99) < 55),
           8'($urandom),
           ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 99) < 8));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
